// File: rtl/turn_scheduler_if.sv
`default_nettype none
// turn_scheduler_if: button, question and checker signals shared between the game front end and turn_scheduler.
interface turn_scheduler_if;
  logic       start;
  logic       buzz_1p;
  logic       buzz_2p;
  logic [2:0] sel_1p;
  logic [2:0] sel_2p;
  logic       dec_1p;
  logic       dec_2p;
  logic       clr_1p;
  logic       clr_2p;
  logic       que_ok;
  logic [1:0] result;
  logic       next_q;
  logic [2:0] sel_out;
  logic       dec_out;
  logic       clr_out;
  logic [1:0] grant;
  logic [1:0] hp_1p;
  logic [1:0] hp_2p;
  logic [3:0] timer;
  logic [1:0] winner;
  logic [2:0] state;

  modport master (
    output start, buzz_1p, buzz_2p, sel_1p, sel_2p, dec_1p, dec_2p, clr_1p, clr_2p,
           que_ok, result,
    input  next_q, sel_out, dec_out, clr_out, grant, hp_1p, hp_2p, timer, winner, state
  );

  modport slave (
    input  start, buzz_1p, buzz_2p, sel_1p, sel_2p, dec_1p, dec_2p, clr_1p, clr_2p,
           que_ok, result,
    output next_q, sel_out, dec_out, clr_out, grant, hp_1p, hp_2p, timer, winner, state
  );
endinterface
`default_nettype wire

// File: rtl/turn_scheduler.sv
`default_nettype none
// turn_scheduler: two-player buzz-in round sequencer with HP bookkeeping and answer countdown.
// Optional WRONG_LOCKOUT_EN: a player penalised for wrong/timeout sits out the next buzz round.
module turn_scheduler #(
  parameter int TICK_DIV   = 50000000,
  parameter int ANSWER_SEC = 9,
  parameter int HP_INIT    = 3,
  parameter int JUDGE_CYC  = 25000000
) (
  input wire              clk,
  input wire              rst,
  turn_scheduler_if.slave bus
);

  localparam int c_presc_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_judge_w = (JUDGE_CYC > 1) ? $clog2(JUDGE_CYC) : 1;
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);
  localparam logic [c_judge_w-1:0] c_judge_last = c_judge_w'(JUDGE_CYC - 1);
  localparam logic [1:0] c_hp_init    = 2'(HP_INIT);
  localparam logic [3:0] c_answer_sec = 4'(ANSWER_SEC);
  localparam logic [1:0] c_none       = 2'b00;
  localparam logic [1:0] c_p1         = 2'b01;
  localparam logic [1:0] c_p2         = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_Q   = 3'd1,
    S_BUZZ     = 3'd2,
    S_ANSWER   = 3'd3,
    S_JUDGE    = 3'd4,
    S_GAMEOVER = 3'd5
  } state_t;

  state_t                 r_state;
  logic                   r_next_q;
  logic [1:0]             r_grant;
  logic [1:0]             r_hp_1p;
  logic [1:0]             r_hp_2p;
  logic [1:0]             r_winner;
  logic [3:0]             r_timer;
  logic                   r_tie_2p;
  logic [c_presc_w-1:0]   r_presc;
  logic [c_judge_w-1:0]   r_judge;

  logic [1:0] w_buzz;
  logic [1:0] w_grant;
  logic       w_correct;
  logic       w_wrong;
  logic       w_tick;
  logic       w_timeout;
  logic [2:0] w_sel;
  logic       w_dec;
  logic       w_clr;

  // Bit 0 is 1P and bit 1 is 2P, matching the one-hot GRANT encoding.
`ifdef WRONG_LOCKOUT_EN
  logic [1:0] r_lock;
  assign w_buzz = {bus.buzz_2p, bus.buzz_1p} & ~r_lock;
`else
  assign w_buzz = {bus.buzz_2p, bus.buzz_1p};
`endif

  assign w_correct = (bus.result == 2'b01);
  assign w_wrong   = (bus.result == 2'b10);
  assign w_tick    = (r_presc == c_presc_last);
  assign w_timeout = w_tick && (r_timer == 4'd1);

  always_comb begin
    w_grant = c_none;
    case (w_buzz)
      2'b01:   w_grant = c_p1;
      2'b10:   w_grant = c_p2;
      2'b11:   w_grant = r_tie_2p ? c_p2 : c_p1;
      default: w_grant = c_none;
    endcase
  end

  function automatic logic [1:0] dec_sat(input logic [1:0] hp);
    return (hp == 2'd0) ? 2'd0 : hp - 2'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_next_q <= 1'b0;
      r_grant  <= c_none;
      r_hp_1p  <= c_hp_init;
      r_hp_2p  <= c_hp_init;
      r_winner <= c_none;
      r_timer  <= 4'd0;
      r_tie_2p <= 1'b0;
      r_presc  <= '0;
      r_judge  <= '0;
`ifdef WRONG_LOCKOUT_EN
      r_lock   <= 2'b00;
`endif
    end else begin
      r_next_q <= 1'b0;
      case (r_state)
        S_IDLE, S_GAMEOVER: begin
          if (bus.start) begin
            r_state  <= S_WAIT_Q;
            r_next_q <= 1'b1;
            r_hp_1p  <= c_hp_init;
            r_hp_2p  <= c_hp_init;
            r_winner <= c_none;
`ifdef WRONG_LOCKOUT_EN
            r_lock   <= 2'b00;
`endif
          end
        end
        S_WAIT_Q: begin
          if (bus.que_ok) r_state <= S_BUZZ;
        end
        S_BUZZ: begin
          if (w_grant != c_none) begin
            r_grant <= w_grant;
            if (&w_buzz) r_tie_2p <= ~r_tie_2p;
            r_state <= S_ANSWER;
            r_timer <= c_answer_sec;
            r_presc <= '0;
`ifdef WRONG_LOCKOUT_EN
            r_lock  <= 2'b00;
`endif
          end
        end
        S_ANSWER: begin
          if (w_tick) begin
            r_presc <= '0;
            r_timer <= r_timer - 4'd1;
          end else begin
            r_presc <= r_presc + c_presc_w'(1);
          end
          // A verdict arriving on the timeout edge wins over the timeout.
          if (w_correct) begin
            if (r_grant == c_p1) r_hp_2p <= dec_sat(r_hp_2p);
            else                 r_hp_1p <= dec_sat(r_hp_1p);
            r_state <= S_JUDGE;
            r_judge <= '0;
          end else if (w_wrong || w_timeout) begin
            if (r_grant == c_p1) r_hp_1p <= dec_sat(r_hp_1p);
            else                 r_hp_2p <= dec_sat(r_hp_2p);
`ifdef WRONG_LOCKOUT_EN
            r_lock  <= r_grant;
`endif
            r_state <= S_JUDGE;
            r_judge <= '0;
          end
        end
        S_JUDGE: begin
          if (r_judge == c_judge_last) begin
            r_grant <= c_none;
            if ((r_hp_1p == 2'd0) || (r_hp_2p == 2'd0)) begin
              r_state  <= S_GAMEOVER;
              r_winner <= (r_hp_1p != 2'd0) ? c_p1 : c_p2;
            end else begin
              r_state  <= S_WAIT_Q;
              r_next_q <= 1'b1;
            end
          end else begin
            r_judge <= r_judge + c_judge_w'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Only the granted player reaches the answer datapath, and only while answering.
  always_comb begin
    w_sel = 3'd0;
    w_dec = 1'b0;
    w_clr = 1'b0;
    if (r_state == S_ANSWER) begin
      if (r_grant == c_p1) begin
        w_sel = bus.sel_1p;
        w_dec = bus.dec_1p;
        w_clr = bus.clr_1p;
      end else if (r_grant == c_p2) begin
        w_sel = bus.sel_2p;
        w_dec = bus.dec_2p;
        w_clr = bus.clr_2p;
      end
    end
  end

  assign bus.sel_out = w_sel;
  assign bus.dec_out = w_dec;
  assign bus.clr_out = w_clr;
  assign bus.next_q  = r_next_q;
  assign bus.grant   = r_grant;
  assign bus.hp_1p   = r_hp_1p;
  assign bus.hp_2p   = r_hp_2p;
  assign bus.timer   = r_timer;
  assign bus.winner  = r_winner;
  assign bus.state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_turn_scheduler.sv
`default_nettype none
// tb_turn_scheduler: randomized rounds against a rule-level game model; round outcomes checked by a JUDGE-entry scoreboard.
module tb_turn_scheduler;
  localparam int TICK_DIV   = 4;
  localparam int ANSWER_SEC = 3;
  localparam int HP_INIT    = 2;
  localparam int JUDGE_CYC  = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  turn_scheduler_if bus ();

  turn_scheduler #(
    .TICK_DIV  (TICK_DIV),
    .ANSWER_SEC(ANSWER_SEC),
    .HP_INIT   (HP_INIT),
    .JUDGE_CYC (JUDGE_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int grant;
    int hp1;
    int hp2;
    bit over;
    int winner;
  } exp_t;

  exp_t sb[$];

  // Game model: HP per player, who wins the next tie (1 or 2), who is locked out (0 = nobody).
  int m_hp1, m_hp2, m_tie, m_lock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic summary_and_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic bail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
    summary_and_finish();
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (bus.state === s) return;
      @(negedge clk);
    end
    bail(name);
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    m_hp1 = HP_INIT;
    m_hp2 = HP_INIT;
    m_lock = 0;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_state", bus.state, 1);
    check("start_hp1", bus.hp_1p, HP_INIT);
    check("start_hp2", bus.hp_2p, HP_INIT);
    check("start_winner", bus.winner, 0);
  endtask

  task automatic play_round(input bit force_tie, output bit over);
    int g, pat, v, d, k, total;
    exp_t e;
    logic [4:0] want;
    wait_state(3'd1, 20, "wait_q_entry");
    check("next_q_first", bus.next_q, 1);
    for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
      bus.buzz_1p = 1'($urandom);
      bus.buzz_2p = 1'($urandom);
      @(negedge clk);
      bus.buzz_1p = 1'b0;
      bus.buzz_2p = 1'b0;
      check("next_q_once", bus.next_q, 0);
      check("wait_q_hold", bus.state, 1);
    end
    bus.que_ok = 1'b1;
    @(negedge clk);
    bus.que_ok = 1'b0;
    check("buzz_entry", bus.state, 2);

    g = 0;
    for (int it = 0; it < 60 && g == 0; it++) begin
      pat = force_tie ? 3 : int'($urandom_range(0, 3));
      bus.buzz_1p = pat[0];
      bus.buzz_2p = pat[1];
      if (m_lock == 1) pat = pat & 2;
      if (m_lock == 2) pat = pat & 1;
      if (pat == 3) begin
        g = m_tie;
        m_tie = 3 - m_tie;
      end else if (pat == 1) g = 1;
      else if (pat == 2) g = 2;
      @(negedge clk);
      bus.buzz_1p = 1'b0;
      bus.buzz_2p = 1'b0;
      if (g == 0) check("buzz_no_grant", bus.state, 2);
    end
    if (g == 0) bail("buzz_grant");
    m_lock = 0;
    check("answer_state", bus.state, 3);
    check("answer_grant", bus.grant, g);

    total = ANSWER_SEC * TICK_DIV;
    v = int'($urandom_range(0, 2));
    d = int'($urandom_range(0, total - 1));
    k = 0;
    forever begin
      check("timer", bus.timer, ANSWER_SEC - k / TICK_DIV);
      bus.sel_1p = 3'($urandom);
      bus.sel_2p = 3'($urandom);
      bus.dec_1p = 1'($urandom);
      bus.dec_2p = 1'($urandom);
      bus.clr_1p = 1'($urandom);
      bus.clr_2p = 1'($urandom);
      bus.start  = ($urandom_range(0, 15) == 0);
      bus.result = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'b00;
      #1;
      want = (g == 1) ? {bus.sel_1p, bus.dec_1p, bus.clr_1p} : {bus.sel_2p, bus.dec_2p, bus.clr_2p};
      check("answer_mux", {bus.sel_out, bus.dec_out, bus.clr_out}, want);
      if ((v != 2 && k == d) || (v == 2 && k == total - 1)) begin
        if (v == 0) begin
          bus.result = 2'b01;
          if (g == 1) m_hp2 = (m_hp2 > 0) ? m_hp2 - 1 : 0;
          else        m_hp1 = (m_hp1 > 0) ? m_hp1 - 1 : 0;
        end else begin
          if (v == 1) bus.result = 2'b10;
          if (g == 1) m_hp1 = (m_hp1 > 0) ? m_hp1 - 1 : 0;
          else        m_hp2 = (m_hp2 > 0) ? m_hp2 - 1 : 0;
`ifdef WRONG_LOCKOUT_EN
          m_lock = g;
`endif
        end
        e.grant = g;
        e.hp1 = m_hp1;
        e.hp2 = m_hp2;
        e.over = (m_hp1 == 0) || (m_hp2 == 0);
        e.winner = (m_hp1 != 0) ? 1 : 2;
        sb.push_back(e);
        bus.sel_1p = 3'd7; bus.sel_2p = 3'd7;
        bus.dec_1p = 1'b1; bus.dec_2p = 1'b1;
        bus.clr_1p = 1'b1; bus.clr_2p = 1'b1;
        @(negedge clk);
        bus.result = 2'b00;
        bus.start  = 1'b0;
        over = e.over;
        return;
      end
      @(negedge clk);
      bus.result = 2'b00;
      bus.start  = 1'b0;
      k++;
      if (k >= total) bail("answer_timeout");
      check("answer_hold", bus.state, 3);
    end
  endtask

  initial begin : monitor
    logic [2:0] prev;
    exp_t cur;
    int jcyc;
    prev = 3'd0;
    jcyc = 0;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      if (bus.state == 3'd4 && prev != 3'd4) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL judge_unexpected actual=judge required=no_judge");
        end else begin
          cur = sb.pop_front();
          check("judge_grant", bus.grant, cur.grant);
          check("judge_hp1", bus.hp_1p, cur.hp1);
          check("judge_hp2", bus.hp_2p, cur.hp2);
        end
        jcyc = 0;
      end
      if (bus.state == 3'd4) begin
        jcyc++;
        check("judge_mux_zero", {bus.sel_out, bus.dec_out, bus.clr_out}, 0);
      end
      if (prev == 3'd4 && bus.state != 3'd4) begin
        check("judge_len", jcyc, JUDGE_CYC);
        check("after_judge_state", bus.state, cur.over ? 5 : 1);
        check("after_judge_winner", bus.winner, cur.over ? cur.winner : 0);
        check("after_judge_grant", bus.grant, 0);
      end
      prev = bus.state;
    end
  end

  initial begin : watchdog
    #400000;
    bail("watchdog");
  end

  initial begin : driver
    bit over;
    bus.start = 0; bus.buzz_1p = 0; bus.buzz_2p = 0;
    bus.sel_1p = 0; bus.sel_2p = 0;
    bus.dec_1p = 0; bus.dec_2p = 0; bus.clr_1p = 0; bus.clr_2p = 0;
    bus.que_ok = 0; bus.result = 0;
    m_tie = 1; m_lock = 0; m_hp1 = HP_INIT; m_hp2 = HP_INIT;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", bus.state, 0);
    check("rst_next_q", bus.next_q, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_hp1", bus.hp_1p, HP_INIT);
    check("rst_hp2", bus.hp_2p, HP_INIT);
    check("rst_timer", bus.timer, 0);
    check("rst_winner", bus.winner, 0);

    for (int gm = 0; gm < 6; gm++) begin
      start_game();
      over = 1'b0;
      for (int r = 0; r < 8 && !over; r++) play_round(gm == 0 && r < 2, over);
      if (!over) bail("game_end");
      wait_state(3'd5, 10, "gameover_entry");
      bus.buzz_1p = 1'b1;
      bus.buzz_2p = 1'b1;
      @(negedge clk);
      bus.buzz_1p = 1'b0;
      bus.buzz_2p = 1'b0;
      @(negedge clk);
      check("gameover_hold", bus.state, 5);
      check("gameover_hp1", bus.hp_1p, m_hp1);
      check("gameover_hp2", bus.hp_2p, m_hp2);
    end

    // Reset while answering: the verdict on the reset cycle must be lost.
    start_game();
    bus.que_ok = 1'b1;
    @(negedge clk);
    bus.que_ok = 1'b0;
    bus.buzz_1p = 1'b1;
    @(negedge clk);
    bus.buzz_1p = 1'b0;
    check("pre_rst_state", bus.state, 3);
    bus.result = 2'b01;
    rst = 1'b1;
    #1;
    check("async_rst_state", bus.state, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.result = 2'b00;
    m_tie = 1;
    m_lock = 0;
    @(negedge clk);
    check("mid_rst_state", bus.state, 0);
    check("mid_rst_hp1", bus.hp_1p, HP_INIT);
    check("mid_rst_hp2", bus.hp_2p, HP_INIT);
    check("mid_rst_grant", bus.grant, 0);
    check("mid_rst_timer", bus.timer, 0);

    start_game();
    play_round(1'b1, over);
    repeat (JUDGE_CYC + 3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    summary_and_finish();
  end

endmodule
`default_nettype wire
